mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter that shares the single-port word RAM between the instruction-fetch stage (IF port) and the load/store stage (data port). It sits between the pipeline and the RAM and sequences each access through a fixed three-state handshake. Data accesses win, with a starvation bound so fetch always makes progress. The RAM's combinational read and level-sensitive write are driven only from registered signals.

## Interface
- MEM_SIZE, 1024: RAM depth in 32-bit words; word addresses ≥ MEM_SIZE are out of range.
- MAX_DATA_RUN, 4: maximum consecutive data grants while IF is waiting; range 1..15.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- if_req  in  1  fetch request; held high until if_ack.
- if_adr  in  32  fetch word address; stable while if_req is high.
- if_ack  out  1  one-cycle completion pulse.
- if_rdata  out  32  fetched word; valid in the if_ack cycle and held until the next if_ack.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1 = store, 0 = load; stable while d_req is high.
- d_adr  in  32  data word address.
- d_wdata  in  32  store data.
- d_ack  out  1  one-cycle completion pulse.
- d_rdata  out  32  load data; valid in the d_ack cycle and held until the next d_ack; 0 after a store.
- d_err  out  1  out-of-range flag; valid with d_ack.
- ram_adr  out  32  RAM word address.
- ram_load  out  1  RAM write strobe.
- ram_in  out  32  RAM write data.
- ram_out  in  32  RAM combinational read data.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE, no request pending: remain in IDLE.
- IDLE, request pending:
  - pick a winner;
  - register grant (IF/D), address, we, wdata and range flag;
  - go to ACCESS.
- Winner selection:
  - d_req alone: data wins.
  - if_req alone: IF wins.
  - Both pending: data wins unless run_cnt == MAX_DATA_RUN, in which case IF wins.
- run_cnt (4-bit):
  - increments on a data grant while if_req is high;
  - clears on any IF grant;
  - clears on a data grant while if_req is low.
- ACCESS:
  - ram_adr = registered address.
  - ram_in = registered wdata.
  - ram_load = we AND grant == D AND in range.
  - At the clock edge, capture ram_out into the granted port's rdata register, then go to RESP.
  - Store or out-of-range access: capture 0 instead of ram_out.
- RESP:
  - registered ack is high for the granted port only;
  - d_err = registered range flag (data grant only);
  - no new grant is taken;
  - go to IDLE.
- The requester drops or changes req in the cycle after ack; the arbiter never samples req in RESP, so a single request is never double-issued.
- An IF address is never out of range in practice. If it is, if_rdata = 0 and no error is reported.
- Outside ACCESS: ram_load = 0, ram_adr = 0, ram_in = 0.

## Timing
- Requester's req rises before edge N with FSM in IDLE:
  - ACCESS during cycle N+1;
  - ack and rdata during cycle N+2;
  - back to IDLE at N+3.
- Latency is 2 cycles from grant edge to ack. Peak throughput is one access per 3 cycles.
- A new req asserted in the cycle after ack is granted at the following edge (no dead cycle beyond RESP).
- Reset values:
  - state IDLE, run_cnt 0;
  - if_ack 0, d_ack 0, d_err 0;
  - if_rdata 0, d_rdata 0;
  - ram_load 0, ram_adr 0, ram_in 0.
- Reset asserted in ACCESS:
  - ram_load drops immediately (asynchronously);
  - the write may or may not have landed;
  - no ack is issued and the requester must reissue.
- Reset asserted in RESP: the ack pulse is cut and rdata clears to 0.
- Simultaneous requests with run_cnt == MAX_DATA_RUN: IF is granted and run_cnt clears at the grant edge.
- d_adr = MEM_SIZE exactly is out of range. d_adr = MEM_SIZE-1 is in range.
- ram_load is never high for more than one consecutive cycle per grant.

## Structure
- Shared package mem_pkg holds:
  - state encoding (IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2);
  - grant encoding (GNT_IF = 1'b0, GNT_D = 1'b1);
  - the MEM_SIZE default constant, shared with the RAM.
- Sub-module mem_arb_pick: combinational winner select plus run_cnt update, kept separate so fairness is unit-testable.
- The FSM and datapath registers stay in mem_arbiter.

## Test plan
- Reset, then d_req = 1, d_we = 1, d_adr = 5, d_wdata = 0xDEADBEEF:
  - ram_load high for exactly 1 cycle with ram_adr = 5;
  - d_ack 2 cycles after grant;
  - d_rdata = 0, d_err = 0.
- Follow with a load from adr 5 -> d_rdata = 0xDEADBEEF in the d_ack cycle; if_rdata unchanged.
- if_req and d_req held continuously with MAX_DATA_RUN = 4 -> grant sequence D,D,D,D,IF,D,D,D,D,IF; no double acks.
- Store to adr 1024 (MEM_SIZE = 1024) -> ram_load never asserts; d_ack with d_err = 1 and d_rdata = 0.
- Assert rst mid-ACCESS of an IF fetch -> outputs go to reset values within the same cycle; no if_ack; a reissued fetch completes normally.
- Back-to-back IF requests (req re-asserted the cycle after ack, adr 0 then 1) -> acks 3 cycles apart with correct words.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory arbiter and the word RAM it fronts.
package mem_pkg;

    // Default RAM depth in 32-bit words; the RAM uses the same constant.
    localparam int MEM_SIZE_DFLT = 1024;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } gnt_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between fetch and data requests, plus the data-run counter
// update that bounds how long fetch can be starved.
module mem_arb_pick
    import mem_pkg::*;
#(
    parameter int MAX_DATA_RUN = 4
) (
    input  logic       if_req,
    input  logic       d_req,
    input  logic [3:0] run_cnt,
    output logic       any_req,
    output logic       gnt,
    output logic [3:0] run_cnt_nxt
);

    // Data wins unless it has already won MAX_DATA_RUN times in a row
    // while fetch was waiting; the counter only tracks runs that starve fetch.
    always_comb begin
        any_req     = if_req | d_req;
        gnt         = GNT_IF;
        run_cnt_nxt = 4'd0;
        if (d_req && !(if_req && (run_cnt == 4'(MAX_DATA_RUN)))) begin
            gnt = GNT_D;
        end
        if ((gnt == GNT_D) && if_req) begin
            run_cnt_nxt = run_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port word RAM between instruction fetch and load/store.
// Every access runs IDLE -> ACCESS -> RESP; the RAM is driven only while in
// ACCESS and only from registered address/data/strobe sources.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int MEM_SIZE     = MEM_SIZE_DFLT,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_adr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_adr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] ram_adr,
    output logic        ram_load,
    output logic [31:0] ram_in,
    input  logic [31:0] ram_out
);

    state_t      state;
    logic        gnt_r;
    logic [31:0] adr_r;
    logic [31:0] wdata_r;
    logic        we_r;
    logic        oor_r;
    logic [3:0]  run_cnt;

    logic        any_req;
    logic        pick_gnt;
    logic [3:0]  run_cnt_nxt;
    logic [31:0] adr_sel;
    logic        oor_sel;

    mem_arb_pick #(
        .MAX_DATA_RUN(MAX_DATA_RUN)
    ) u_pick (
        .if_req     (if_req),
        .d_req      (d_req),
        .run_cnt    (run_cnt),
        .any_req    (any_req),
        .gnt        (pick_gnt),
        .run_cnt_nxt(run_cnt_nxt)
    );

    // Address of the would-be winner and its range check, used at the grant edge.
    always_comb begin
        adr_sel = (pick_gnt == GNT_D) ? d_adr : if_adr;
        oor_sel = (adr_sel >= 32'(MEM_SIZE));
    end

    // RAM drive: decoded from registered state so an async reset drops the
    // write strobe immediately; everything is zero outside ACCESS.
    always_comb begin
        ram_adr  = '0;
        ram_in   = '0;
        ram_load = 1'b0;
        if (state == ACCESS) begin
            ram_adr  = adr_r;
            ram_in   = wdata_r;
            ram_load = we_r & (gnt_r == GNT_D) & ~oor_r;
        end
    end

    // Access sequencer: grant in IDLE, capture read data in ACCESS, pulse ack in RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt_r    <= GNT_IF;
            adr_r    <= '0;
            wdata_r  <= '0;
            we_r     <= 1'b0;
            oor_r    <= 1'b0;
            run_cnt  <= 4'd0;
            if_ack   <= 1'b0;
            d_ack    <= 1'b0;
            d_err    <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt_r   <= pick_gnt;
                        adr_r   <= adr_sel;
                        wdata_r <= d_wdata;
                        we_r    <= (pick_gnt == GNT_D) & d_we;
                        oor_r   <= oor_sel;
                        run_cnt <= run_cnt_nxt;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (gnt_r == GNT_D) begin
                        d_rdata <= (we_r | oor_r) ? 32'd0 : ram_out;
                        d_ack   <= 1'b1;
                        d_err   <= oor_r;
                    end else begin
                        if_rdata <= oor_r ? 32'd0 : ram_out;
                        if_ack   <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if_ack <= 1'b0;
                    d_ack  <= 1'b0;
                    d_err  <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
